song_reader: RTL and testbench

Sequencer directly upstream of `note_player`. Fetches note/duration words for the selected song from an external synchronous song ROM, presents each note to `note_player` with a one-cycle load pulse, and advances on the player's `done_with_note`. Handles start, pause, end-of-song detection and song completion signalling.

---
 rtl/song_reader.sv | 144 ++++++++++++++
 tb/tb_song_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// song_reader: walks a song ROM one note at a time and hands each note to note_player.
// Define SONG_READER_LOOP_EN to repeat the song instead of returning to IDLE at its end.
module song_reader #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic [SONG_W-1:0]       song,
  input  logic                    note_done,
  output logic [SONG_W+IDX_W-1:0] rom_addr,
  input  logic [11:0]             rom_dout,
  output logic [5:0]              note_to_load,
  output logic [5:0]              duration_to_load,
  output logic                    load_new_note,
  output logic                    song_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    LOAD    = 3'd3,
    PLAYING = 3'd4
  } state_t;

`ifdef SONG_READER_LOOP_EN
  localparam state_t END_STATE = FETCH;
`else
  localparam state_t END_STATE = IDLE;
`endif

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [SONG_W-1:0] song_reg, song_reg_nxt;
  logic [5:0]        note_nxt, dur_nxt;
  logic              play_q;
  logic              armed;
  logic              end_marker;
  logic              last_idx;

  assign rom_addr   = {song_reg, idx};
  assign end_marker = (rom_dout[5:0] == 6'd0);
  assign last_idx   = (idx == {IDX_W{1'b1}});

  // State and datapath registers. armed stays low for the first clock after
  // reset so a play level already high at release is not taken as an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      idx              <= {IDX_W{1'b0}};
      song_reg         <= {SONG_W{1'b0}};
      play_q           <= 1'b0;
      armed            <= 1'b0;
      note_to_load     <= 6'd0;
      duration_to_load <= 6'd0;
    end else begin
      state            <= state_nxt;
      idx              <= idx_nxt;
      song_reg         <= song_reg_nxt;
      play_q           <= play;
      armed            <= 1'b1;
      note_to_load     <= note_nxt;
      duration_to_load <= dur_nxt;
    end
  end

  // Next-state logic; every non-idle state stalls while play is low.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    song_reg_nxt = song_reg;
    note_nxt     = note_to_load;
    dur_nxt      = duration_to_load;
    case (state)
      IDLE: begin
        idx_nxt = {IDX_W{1'b0}};
        if (play && !play_q && armed) begin
          song_reg_nxt = song;
          state_nxt    = FETCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      FETCH: begin
        if (play) state_nxt = DECODE;
        else      state_nxt = FETCH;
      end
      DECODE: begin
        if (!play) begin
          state_nxt = DECODE;
        end else if (end_marker) begin
          idx_nxt   = {IDX_W{1'b0}};
          state_nxt = END_STATE;
        end else begin
          note_nxt  = rom_dout[11:6];
          dur_nxt   = rom_dout[5:0];
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (play) state_nxt = PLAYING;
        else      state_nxt = LOAD;
      end
      PLAYING: begin
        if (!(play && note_done)) begin
          state_nxt = PLAYING;
        end else if (last_idx) begin
          idx_nxt   = {IDX_W{1'b0}};
          state_nxt = END_STATE;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = FETCH;
        end
      end
      default: begin
        idx_nxt   = {IDX_W{1'b0}};
        state_nxt = IDLE;
      end
    endcase
  end

  // Strobes are gated by play so nothing fires while paused.
  always_comb begin
    load_new_note = 1'b0;
    song_done     = 1'b0;
    if (play) begin
      case (state)
        DECODE:  song_done     = end_marker;
        LOAD:    load_new_note = 1'b1;
        PLAYING: song_done     = note_done & last_idx;
        default: begin
          load_new_note = 1'b0;
          song_done     = 1'b0;
        end
      endcase
    end else begin
      load_new_note = 1'b0;
      song_done     = 1'b0;
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Scoreboard bench for song_reader: a song-level model queues expected loads and
// song_done pulses with their cycle numbers; a negedge monitor pops and compares.
module tb_song_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_dout;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic        song_done;

  logic [11:0] rom [0:127];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [1:0] rs;

  typedef struct {
    bit         is_done;
    logic [5:0] note;
    logic [5:0] dur;
    logic [6:0] addr;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  song_reader #(.SONG_W(2), .IDX_W(5)) dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .note_done(note_done),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .load_new_note(load_new_note),
    .song_done(song_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_dout <= rom[rom_addr];

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_load(input logic [6:0] a, input int c);
    exp_t e;
    e.is_done = 1'b0;
    e.note    = rom[a][11:6];
    e.dur     = rom[a][5:0];
    e.addr    = a;
    e.cyc     = c;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done(input int c);
    exp_t e;
    e.is_done = 1'b1;
    e.note    = 6'd0;
    e.dur     = 6'd0;
    e.addr    = 7'd0;
    e.cyc     = c;
    exp_q.push_back(e);
  endfunction

  function automatic void fill_song(input logic [1:0] s, input int marker);
    for (int i = 0; i < 32; i++) begin
      logic [6:0] a;
      a = {s, i[4:0]};
      rom[a] = {6'($urandom), 6'($urandom_range(1, 63))};
      if ($urandom_range(0, 3) == 0) rom[a][11:6] = 6'd0;
      if (i == marker) rom[a][5:0] = 6'd0;
    end
  endfunction

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset && (load_new_note || song_done)) begin
      chk("strobe_overlap", int'(load_new_note && song_done), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", int'(song_done), int'(e.is_done));
        chk("event_cycle", cyc, e.cyc);
        if (!e.is_done) begin
          chk("note", int'(note_to_load), int'(e.note));
          chk("duration", int'(duration_to_load), int'(e.dur));
          chk("load_addr", int'(rom_addr), int'(e.addr));
          chk("load_play_high", int'(play), 1);
        end
      end
    end
  end

  task automatic wait_load();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load_new_note && n < 300);
    chk("load_timeout", int'(load_new_note), 1);
  endtask

  // Plays song s to its end: the model walks the ROM image, acting as note_player.
  task automatic run_song(input logic [1:0] s, input int pause_at, input int chg_at);
    int idx;
    int f;
    int n;
    int fn;
    logic [6:0] a;
    play = 1'b0;
    note_done = 1'b0;
    song = s;
    @(posedge clk); #1;
    play = 1'b1;
    f = cyc + 1;
    idx = 0;
    fn = 0;
    forever begin
      a = {s, idx[4:0]};
      if (rom[a][5:0] == 6'd0) begin
        push_done(f + 1);
        fn = f + 2;
        break;
      end
      push_load(a, f + 2);
      wait_load();
      if (idx == chg_at) song = ~s;
      repeat ($urandom_range(1, 8)) @(posedge clk);
      #1;
      if (idx == pause_at) begin
        play = 1'b0;
        note_done = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("pause_addr", int'(rom_addr), int'(a));
        play = 1'b1;
      end
      note_done = 1'b1;
      n = cyc + 1;
      if (idx == 31) push_done(n - 1);
      @(posedge clk); #1;
      note_done = 1'b0;
      if (idx == 31) begin
        fn = n;
        break;
      end
      idx++;
      f = n;
    end
`ifdef SONG_READER_LOOP_EN
    a = {s, 5'd0};
    push_load(a, fn + 2);
    wait_load();
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
`else
    repeat (4) @(posedge clk);
    #1;
    chk("idle_addr", int'(rom_addr), int'({s, 5'd0}));
    chk("end_cycle_seen", int'(cyc > fn), 1);
`endif
    play = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 12'd0;
    reset = 1'b0;
    play = 1'b1;
    song = 2'd0;
    note_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_note", int'(note_to_load), 0);
    chk("rst_duration", int'(duration_to_load), 0);
    chk("rst_load", int'(load_new_note), 0);
    chk("rst_song_done", int'(song_done), 0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("held_play_no_start", int'(rom_addr), 0);

    fill_song(2'd1, 3);
    rom[32] = {6'h15, 6'd6};
    run_song(2'd1, -1, -1);

    fill_song(2'd2, 99);
    run_song(2'd2, 5, 3);

`ifndef SONG_READER_LOOP_EN
    fill_song(2'd3, 0);
    run_song(2'd3, -1, -1);
`endif

    for (int r = 0; r < 4; r++) begin
      rs = 2'($urandom);
      fill_song(rs, $urandom_range(1, 32));
      run_song(rs, $urandom_range(0, 40), -1);
    end

    // Reset asserted during the LOAD cycle, with play held high across release.
    fill_song(2'd0, 99);
    song = 2'd0;
    play = 1'b0;
    @(posedge clk); #1;
    play = 1'b1;
    push_load(7'd0, cyc + 3);
    wait_load();
    #1 reset = 1'b0;
    #1;
    chk("rstload_load", int'(load_new_note), 0);
    chk("rstload_note", int'(note_to_load), 0);
    chk("rstload_duration", int'(duration_to_load), 0);
    chk("rstload_addr", int'(rom_addr), 0);
    chk("rstload_song_done", int'(song_done), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("rstload_queue", exp_q.size(), 0);

    fill_song(2'd1, 2);
    run_song(2'd1, 0, -1);

    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
